// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C slave error codes, read-sequencer state encoding, width helper
//
// Purpose: constants and types shared by the slave-side I2C sequencers.
// Ports:   none (package).

package i2c_pkg;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_SDA_CHANGE = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

    typedef enum logic [2:0] {
        RB_IDLE      = 3'd0,
        RB_WAIT_RISE = 3'd1,
        RB_HIGH      = 3'd2,
        RB_DONE      = 3'd3,
        RB_ABORT     = 3'd4
    } rb_state_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_scl_edge_detect.sv
// rtl/i2c_scl_edge_detect.sv - rise/fall detector for the synchronised scl line
//
// Purpose: registers scl once and flags its rising and falling edges.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high
//   scl    in   bus clock, already synchronised to clock
//   rise   out  scl went 0 -> 1 (combinational, valid in the edge cycle)
//   fall   out  scl went 1 -> 0 (combinational, valid in the edge cycle)

module i2c_scl_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic scl,
    output logic rise,
    output logic fall
);

    logic scl_last;

    // Reset to 1 so a bus that idles high produces no spurious rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_last <= 1'b1;
        end else begin
            scl_last <= scl;
        end
    end

    assign rise = ~scl_last & scl;
    assign fall = scl_last & ~scl;

endmodule

// File: rtl/i2c_slave_read_byte.sv
// rtl/i2c_slave_read_byte.sv - slave-side receive sequencer for one I2C data word
//
// Purpose: once armed by enable, samples sda on DATA_WIDTH scl rising edges, checks
//          sda stays stable while scl is high, aborts on an scl stall, and reports the
//          outcome with a one-cycle finish pulse. The ACK bit is left to the caller.
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high; no finish for a reset-aborted transfer
//   enable      in   start pulse, accepted only in idle
//   scl, sda    in   bus lines, already synchronised to clock
//   busy        out  high from the cycle after enable is accepted until finish
//   data_out    out  last successfully received word, held between transfers
//   finish      out  one-cycle pulse at the end of every transfer (ok or aborted)
//   error       out  with finish: 1 = aborted
//   error_code  out  with finish: 00 ok, 01 sda changed while scl high, 10 timeout

module i2c_slave_read_byte
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  scl,
    input  logic                  sda,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  finish,
    output logic                  error,
    output logic [1:0]            error_code
);

    localparam int BW = cnt_width(DATA_WIDTH);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] T_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    rb_state_t             state;
    rb_state_t             state_next;

    logic                  rise;
    logic                  fall;
    logic                  timed_out;

    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_next;
    logic [TW-1:0]         tcnt;
    logic [TW-1:0]         tcnt_next;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  bit_reg;
    logic                  bit_reg_next;

    logic                  load_data;
    logic                  finish_next;
    logic                  error_next;
    logic [1:0]            code_next;

    i2c_scl_edge_detect u_edge (
        .clock (clock),
        .reset (reset),
        .scl   (scl),
        .rise  (rise),
        .fall  (fall)
    );

    // An edge always clears the counter first, so an edge landing on the
    // terminal count wins over the timeout.
    assign timed_out = (TIMEOUT_CYCLES > 0) && (tcnt == T_LAST);

    // Shift register with the new sda bit entering at the end opposite the
    // direction of travel, so the first bus bit finishes at the chosen end.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST != 0) begin
            shifted    = shift << 1;
            shifted[0] = sda;
        end else begin
            shifted                 = shift >> 1;
            shifted[DATA_WIDTH-1]   = sda;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        tcnt_next    = tcnt;
        shift_next   = shift;
        bit_reg_next = bit_reg;
        load_data    = 1'b0;
        finish_next  = 1'b0;
        error_next   = 1'b0;
        code_next    = ERR_NONE;

        case (state)
            RB_IDLE: begin
                // A high phase already in progress is skipped: only a rise seen
                // from WAIT_RISE onwards is sampled.
                if (enable) begin
                    state_next   = RB_WAIT_RISE;
                    bit_cnt_next = '0;
                    tcnt_next    = '0;
                    shift_next   = '0;
                end
            end

            RB_WAIT_RISE: begin
                if (rise) begin
                    bit_reg_next = sda;
                    shift_next   = shifted;
                    tcnt_next    = '0;
                    state_next   = RB_HIGH;
                end else if (fall) begin
                    tcnt_next = '0;
                end else if (timed_out) begin
                    state_next  = RB_ABORT;
                    finish_next = 1'b1;
                    error_next  = 1'b1;
                    code_next   = ERR_TIMEOUT;
                end else if (TIMEOUT_CYCLES > 0) begin
                    tcnt_next = tcnt + 1'b1;
                end
            end

            RB_HIGH: begin
                // In the fall cycle scl is already low, so sda is free to move.
                if (fall) begin
                    tcnt_next = '0;
                    if (bit_cnt == LAST_BIT) begin
                        state_next  = RB_DONE;
                        load_data   = 1'b1;
                        finish_next = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        state_next   = RB_WAIT_RISE;
                    end
                end else if (scl && (sda != bit_reg)) begin
                    state_next  = RB_ABORT;
                    finish_next = 1'b1;
                    error_next  = 1'b1;
                    code_next   = ERR_SDA_CHANGE;
                end else if (rise) begin
                    tcnt_next = '0;
                end else if (timed_out) begin
                    state_next  = RB_ABORT;
                    finish_next = 1'b1;
                    error_next  = 1'b1;
                    code_next   = ERR_TIMEOUT;
                end else if (TIMEOUT_CYCLES > 0) begin
                    tcnt_next = tcnt + 1'b1;
                end
            end

            // Result registers were loaded on entry, so finish is high for
            // exactly this one cycle while busy is still asserted.
            RB_DONE:  state_next = RB_IDLE;
            RB_ABORT: state_next = RB_IDLE;

            default:  state_next = RB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt    <= '0;
            tcnt       <= '0;
            shift      <= '0;
            bit_reg    <= 1'b0;
            data_out   <= '0;
            finish     <= 1'b0;
            error      <= 1'b0;
            error_code <= ERR_NONE;
        end else begin
            bit_cnt    <= bit_cnt_next;
            tcnt       <= tcnt_next;
            shift      <= shift_next;
            bit_reg    <= bit_reg_next;
            finish     <= finish_next;
            error      <= error_next;
            error_code <= code_next;
            if (load_data) begin
                data_out <= shift;
            end
        end
    end

    assign busy = (state != RB_IDLE);

endmodule
